vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 Parameter CLK_DIV, 4, clk cycles per pixel.
REQ-010 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-011 clk  in  1  system clock, 100 MHz, rising edge.
REQ-012 reset  in  1  asynchronous, active-high reset.
REQ-013 hsync  out  1  horizontal sync, active low, registered.
REQ-014 vsync  out  1  vertical sync, active low, registered.
REQ-015 video_on  out  1  high while (x,y) is inside the visible area.
REQ-016 p_tick  out  1  one-clk pixel enable, once every CLK_DIV clks.
REQ-017 x  out  10  current pixel column (h_count), 0..799.
REQ-018 y  out  10  current line (v_count), 0..524.
REQ-019 frame_start  out  1  one-clk pulse when (x,y) becomes (0,0).

Function
REQ-020 A divider counter SHALL count 0..CLK_DIV-1 on every clk and wrap to 0.
REQ-021 p_tick SHALL be high exactly during the clk cycle in which the divider equals CLK_DIV-1.
REQ-022 h_count SHALL advance only on a clk edge where p_tick=1; its period is H_TOTAL = 800.
REQ-023 On p_tick with h_count=799, h_count SHALL wrap to 0 and v_count SHALL advance on that same edge.
REQ-024 On p_tick with h_count=799 and v_count=524, both counters SHALL wrap to 0.
REQ-025 hsync SHALL be 0 iff h_count is in [656,751]; otherwise 1.
REQ-026 vsync SHALL be 0 iff v_count is in [490,491]; otherwise 1.
REQ-027 hsync and vsync SHALL be registered from next-count values, so they change on the same edge as x/y (zero cycles of skew).
REQ-028 video_on SHALL be (x<640)&&(y<480), decoded combinationally from registered counts.
REQ-029 frame_start SHALL be registered, high for exactly one clk following the edge where counters wrap to (0,0).
REQ-030 x and y SHALL remain constant for CLK_DIV clks between advances.
REQ-031 All width and compare arithmetic SHALL be unsigned 10-bit, and counts SHALL never exceed their terminal value.
REQ-032 Totals SHALL be derived from the parameters (H_TOTAL = sum of the H_* parameters, V_TOTAL = sum of the V_* parameters), with no literals in the RTL.

Reset
REQ-033 While reset=1, outputs SHALL be: divider=0, x=0, y=0, hsync=1, vsync=1, p_tick=0, frame_start=0.
REQ-034 Reset assertion mid-frame SHALL force the reset values immediately, without waiting for a clock.
REQ-035 After reset deasserts, the first p_tick SHALL appear in the 4th clk cycle, and x SHALL become 1 at the 4th edge.
REQ-036 No frame_start pulse SHALL be generated by reset release itself.

Structure
REQ-037 Timing constants and derived totals SHALL live in the shared package vga_timing_pkg, for reuse by the text and overlay renderers.
REQ-038 The divider SHALL be the sub-module pixel_tick_gen (clk, reset -> p_tick); the counters and sync logic stay in the top level.

Verification
REQ-039 Reset release, run 40 clks -> p_tick high on clks 4, 8, ..., 40 and low otherwise; x advances 0->10.
REQ-040 Line boundary at h=655..752 -> hsync falls on entry to h=656 and rises at h=752 (96 p_ticks low); at h 799->0, y increments by 1.
REQ-041 Full frame -> vsync low for 1600 p_ticks at y=490..491; frame period = 420000 p_ticks = 1,680,000 clks; one frame_start per frame.
REQ-042 video_on check -> 1 at (0,0) and (639,479); 0 at (640,0), (0,480) and (799,524).
REQ-043 Assert reset asynchronously between edges at (x=300, y=100) -> outputs reach reset values before the next edge; after release, counting restarts from (0,0) per REQ-035.
REQ-044 Wrap at (799,524) -> next state is (0,0), frame_start pulses for exactly 1 clk, and hsync/vsync are both 1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and count helpers.
// Reused by the sync generator and by the text/overlay renderers.
package vga_timing_pkg;

  localparam int COUNT_W = 10;
  typedef logic [COUNT_W-1:0] count_t;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int CLK_DIV_DEF   = 4;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Subtraction form avoids overflow of start+len near the top of the count range.
  function automatic logic in_window(count_t c, count_t start, count_t len);
    return (c >= start) && ((c - start) < len);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle driven by vga_sync_gen and consumed by renderers.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   p_tick;
  count_t x;
  count_t y;
  logic   frame_start;

  modport master (
    output hsync, vsync, video_on, p_tick, x, y, frame_start
  );

  modport slave (
    input hsync, vsync, video_on, p_tick, x, y, frame_start
  );

endinterface

// File: rtl/pixel_tick_gen.sv
// Clock divider: one-cycle pixel enable every CLK_DIV clocks.
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= '0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  // Gated by reset so a divide-by-one build still shows no tick while held.
  assign p_tick = !reset && (div_reg == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical counters with registered, zero-skew sync outputs.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam count_t H_LAST       = count_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam count_t V_LAST       = count_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam count_t H_VISIBLE    = count_t'(H_DISPLAY);
  localparam count_t V_VISIBLE    = count_t'(V_DISPLAY);
  localparam count_t H_SYNC_START = count_t'(H_DISPLAY + H_FRONT);
  localparam count_t V_SYNC_START = count_t'(V_DISPLAY + V_FRONT);
  localparam count_t H_SYNC_LEN   = count_t'(H_SYNC);
  localparam count_t V_SYNC_LEN   = count_t'(V_SYNC);

  logic   p_tick;
  count_t h_count_reg, h_count_next;
  count_t v_count_reg, v_count_next;
  logic   hsync_reg;
  logic   vsync_reg;
  logic   frame_start_reg;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  always_comb begin
    h_count_next = h_count_reg;
    v_count_next = v_count_reg;
    if (p_tick) begin
      if (h_count_reg == H_LAST) begin
        h_count_next = '0;
        v_count_next = (v_count_reg == V_LAST) ? '0 : v_count_reg + 1'b1;
      end else begin
        h_count_next = h_count_reg + 1'b1;
      end
    end
  end

  // Syncs decode the next counts so they switch on the same edge as x/y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count_reg     <= '0;
      v_count_reg     <= '0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      h_count_reg     <= h_count_next;
      v_count_reg     <= v_count_next;
      hsync_reg       <= !in_window(h_count_next, H_SYNC_START, H_SYNC_LEN);
      vsync_reg       <= !in_window(v_count_next, V_SYNC_START, V_SYNC_LEN);
      frame_start_reg <= p_tick && (h_count_next == '0) && (v_count_next == '0);
    end
  end

  assign vga.hsync       = hsync_reg;
  assign vga.vsync       = vsync_reg;
  assign vga.p_tick      = p_tick;
  assign vga.x           = h_count_reg;
  assign vga.y           = v_count_reg;
  assign vga.frame_start = frame_start_reg;
  assign vga.video_on    = (h_count_reg < H_VISIBLE) && (v_count_reg < V_VISIBLE);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size generator for line timing, shrunken generator for frame timing.
module tb_vga_sync_gen;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_cmp;
  int   n_bad;

  vga_sync_gen_if vga_a();
  vga_sync_gen_if vga_b();

  vga_sync_gen u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (vga_a)
  );

  // Small geometry: H 8+2+3+2=15 (hsync low x=10..12), V 4+1+2+1=8 (vsync low y=5..6).
  // Frame = 120 pixels = 480 clks.
  vga_sync_gen #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
    .CLK_DIV   (4)
  ) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (vga_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(3);
    n_cmp++; if (vga_a.x !== 10'd0) begin n_bad++; $display("FAIL reset_x got %0d want 0", vga_a.x); end
    n_cmp++; if (vga_a.y !== 10'd0) begin n_bad++; $display("FAIL reset_y got %0d want 0", vga_a.y); end
    n_cmp++; if (vga_a.hsync !== 1'b1) begin n_bad++; $display("FAIL reset_hsync got %b want 1", vga_a.hsync); end
    n_cmp++; if (vga_a.vsync !== 1'b1) begin n_bad++; $display("FAIL reset_vsync got %b want 1", vga_a.vsync); end
    n_cmp++; if (vga_a.p_tick !== 1'b0) begin n_bad++; $display("FAIL reset_p_tick got %b want 0", vga_a.p_tick); end
    n_cmp++; if (vga_a.frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start got %b want 0", vga_a.frame_start); end
    $display("test_reset done");
  endtask

  task automatic test_ptick_startup;
    logic exp_tick;
    int   exp_x;
    rst_a = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      exp_tick = (k % 4 == 0);
      exp_x    = (k - 1) / 4;
      n_cmp++; if (vga_a.p_tick !== exp_tick) begin n_bad++; $display("FAIL startup_p_tick clk %0d got %b want %b", k, vga_a.p_tick, exp_tick); end
      n_cmp++; if (vga_a.x !== 10'(exp_x)) begin n_bad++; $display("FAIL startup_x clk %0d got %0d want %0d", k, vga_a.x, exp_x); end
      n_cmp++; if (vga_a.frame_start !== 1'b0) begin n_bad++; $display("FAIL startup_frame_start clk %0d got %b want 0", k, vga_a.frame_start); end
      step(1);
    end
    n_cmp++; if (vga_a.x !== 10'd10) begin n_bad++; $display("FAIL startup_x_after40 got %0d want 10", vga_a.x); end
    $display("test_ptick_startup done");
  endtask

  task automatic test_line_boundary;
    int   lows;
    logic exp_hs;
    lows = 0;
    step(4 * (655 - 10));
    n_cmp++; if (vga_a.x !== 10'd655) begin n_bad++; $display("FAIL line_x655 got %0d want 655", vga_a.x); end
    n_cmp++; if (vga_a.hsync !== 1'b1) begin n_bad++; $display("FAIL line_hsync655 got %b want 1", vga_a.hsync); end
    for (int h = 656; h <= 752; h++) begin
      step(4);
      exp_hs = (h <= 751) ? 1'b0 : 1'b1;
      n_cmp++; if (vga_a.x !== 10'(h)) begin n_bad++; $display("FAIL line_x got %0d want %0d", vga_a.x, h); end
      n_cmp++; if (vga_a.hsync !== exp_hs) begin n_bad++; $display("FAIL line_hsync x=%0d got %b want %b", h, vga_a.hsync, exp_hs); end
      if (vga_a.hsync === 1'b0) lows++;
    end
    n_cmp++; if (lows !== 96) begin n_bad++; $display("FAIL line_hsync_low_count got %0d want 96", lows); end
    step(4 * (799 - 752));
    n_cmp++; if (vga_a.x !== 10'd799 || vga_a.y !== 10'd0) begin n_bad++; $display("FAIL line_end got (%0d,%0d) want (799,0)", vga_a.x, vga_a.y); end
    step(3);
    n_cmp++; if (vga_a.p_tick !== 1'b1) begin n_bad++; $display("FAIL line_end_p_tick got %b want 1", vga_a.p_tick); end
    step(1);
    n_cmp++; if (vga_a.x !== 10'd0 || vga_a.y !== 10'd1) begin n_bad++; $display("FAIL line_wrap got (%0d,%0d) want (0,1)", vga_a.x, vga_a.y); end
    n_cmp++; if (vga_a.hsync !== 1'b1) begin n_bad++; $display("FAIL line_wrap_hsync got %b want 1", vga_a.hsync); end
    n_cmp++; if (vga_a.frame_start !== 1'b0) begin n_bad++; $display("FAIL line_wrap_frame_start got %b want 0", vga_a.frame_start); end
    $display("test_line_boundary done");
  endtask

  task automatic test_video_on_a;
    n_cmp++; if (vga_a.video_on !== 1'b1) begin n_bad++; $display("FAIL von_a_0_1 got %b want 1", vga_a.video_on); end
    step(4 * 639);
    n_cmp++; if (vga_a.x !== 10'd639 || vga_a.video_on !== 1'b1) begin n_bad++; $display("FAIL von_a_639 got x=%0d von=%b want x=639 von=1", vga_a.x, vga_a.video_on); end
    step(4);
    n_cmp++; if (vga_a.x !== 10'd640 || vga_a.video_on !== 1'b0) begin n_bad++; $display("FAIL von_a_640 got x=%0d von=%b want x=640 von=0", vga_a.x, vga_a.video_on); end
    $display("test_video_on_a done");
  endtask

  task automatic test_async_reset_a;
    step(4 * 60);
    n_cmp++; if (vga_a.x !== 10'd700 || vga_a.hsync !== 1'b0) begin n_bad++; $display("FAIL areset_a_pre got x=%0d hs=%b want x=700 hs=0", vga_a.x, vga_a.hsync); end
    #2 rst_a = 1'b1;
    #1;
    n_cmp++; if (vga_a.x !== 10'd0 || vga_a.y !== 10'd0) begin n_bad++; $display("FAIL areset_a_xy got (%0d,%0d) want (0,0)", vga_a.x, vga_a.y); end
    n_cmp++; if (vga_a.hsync !== 1'b1 || vga_a.vsync !== 1'b1) begin n_bad++; $display("FAIL areset_a_sync got hs=%b vs=%b want 1 1", vga_a.hsync, vga_a.vsync); end
    n_cmp++; if (vga_a.p_tick !== 1'b0 || vga_a.frame_start !== 1'b0) begin n_bad++; $display("FAIL areset_a_pulses got pt=%b fs=%b want 0 0", vga_a.p_tick, vga_a.frame_start); end
    @(negedge clk);
    rst_a = 1'b0;
    step(3);
    n_cmp++; if (vga_a.p_tick !== 1'b1 || vga_a.x !== 10'd0) begin n_bad++; $display("FAIL areset_a_restart got pt=%b x=%0d want 1 0", vga_a.p_tick, vga_a.x); end
    step(1);
    n_cmp++; if (vga_a.x !== 10'd1 || vga_a.frame_start !== 1'b0) begin n_bad++; $display("FAIL areset_a_x1 got x=%0d fs=%b want 1 0", vga_a.x, vga_a.frame_start); end
    $display("test_async_reset_a done");
  endtask

  task automatic test_frame_b;
    int   p, xe, ye, vs_low_ticks, fs_count, fs_first, fs_second;
    logic e_hs, e_vs, e_von, e_fs, e_tick;
    vs_low_ticks = 0; fs_count = 0; fs_first = -1; fs_second = -1;
    rst_b = 1'b0;
    for (int e = 0; e <= 1000; e++) begin
      p      = e / 4;
      xe     = p % 15;
      ye     = (p / 15) % 8;
      e_hs   = !(xe >= 10 && xe <= 12);
      e_vs   = !(ye == 5 || ye == 6);
      e_von  = (xe < 8) && (ye < 4);
      e_fs   = (e > 0) && (e % 480 == 0);
      e_tick = (e % 4 == 3);
      n_cmp++; if (vga_b.x !== 10'(xe) || vga_b.y !== 10'(ye)) begin n_bad++; $display("FAIL frame_xy e=%0d got (%0d,%0d) want (%0d,%0d)", e, vga_b.x, vga_b.y, xe, ye); end
      n_cmp++; if (vga_b.hsync !== e_hs) begin n_bad++; $display("FAIL frame_hsync e=%0d got %b want %b", e, vga_b.hsync, e_hs); end
      n_cmp++; if (vga_b.vsync !== e_vs) begin n_bad++; $display("FAIL frame_vsync e=%0d got %b want %b", e, vga_b.vsync, e_vs); end
      n_cmp++; if (vga_b.video_on !== e_von) begin n_bad++; $display("FAIL frame_video_on e=%0d got %b want %b", e, vga_b.video_on, e_von); end
      n_cmp++; if (vga_b.frame_start !== e_fs) begin n_bad++; $display("FAIL frame_start e=%0d got %b want %b", e, vga_b.frame_start, e_fs); end
      n_cmp++; if (vga_b.p_tick !== e_tick) begin n_bad++; $display("FAIL frame_p_tick e=%0d got %b want %b", e, vga_b.p_tick, e_tick); end
      if (e < 480 && vga_b.p_tick === 1'b1 && vga_b.vsync === 1'b0) vs_low_ticks++;
      if (vga_b.frame_start === 1'b1) begin
        fs_count++;
        if (fs_first < 0) fs_first = e; else if (fs_second < 0) fs_second = e;
      end
      step(1);
    end
    n_cmp++; if (vs_low_ticks !== 30) begin n_bad++; $display("FAIL frame_vsync_low_ticks got %0d want 30", vs_low_ticks); end
    n_cmp++; if (fs_count !== 2) begin n_bad++; $display("FAIL frame_start_count got %0d want 2", fs_count); end
    n_cmp++; if (fs_second - fs_first !== 480) begin n_bad++; $display("FAIL frame_period got %0d want 480", fs_second - fs_first); end
    $display("test_frame_b done");
  endtask

  task automatic restart_b;
    rst_b = 1'b1;
    step(1);
    rst_b = 1'b0;
  endtask

  task automatic test_wrap_b;
    restart_b();
    step(476);
    n_cmp++; if (vga_b.x !== 10'd14 || vga_b.y !== 10'd7) begin n_bad++; $display("FAIL wrap_pre got (%0d,%0d) want (14,7)", vga_b.x, vga_b.y); end
    n_cmp++; if (vga_b.video_on !== 1'b0) begin n_bad++; $display("FAIL wrap_pre_von got %b want 0", vga_b.video_on); end
    step(3);
    n_cmp++; if (vga_b.p_tick !== 1'b1 || vga_b.frame_start !== 1'b0) begin n_bad++; $display("FAIL wrap_tick got pt=%b fs=%b want 1 0", vga_b.p_tick, vga_b.frame_start); end
    step(1);
    n_cmp++; if (vga_b.x !== 10'd0 || vga_b.y !== 10'd0) begin n_bad++; $display("FAIL wrap_xy got (%0d,%0d) want (0,0)", vga_b.x, vga_b.y); end
    n_cmp++; if (vga_b.frame_start !== 1'b1) begin n_bad++; $display("FAIL wrap_frame_start got %b want 1", vga_b.frame_start); end
    n_cmp++; if (vga_b.hsync !== 1'b1 || vga_b.vsync !== 1'b1) begin n_bad++; $display("FAIL wrap_sync got hs=%b vs=%b want 1 1", vga_b.hsync, vga_b.vsync); end
    n_cmp++; if (vga_b.video_on !== 1'b1) begin n_bad++; $display("FAIL wrap_von got %b want 1", vga_b.video_on); end
    step(1);
    n_cmp++; if (vga_b.frame_start !== 1'b0) begin n_bad++; $display("FAIL wrap_frame_start_width got %b want 0", vga_b.frame_start); end
    $display("test_wrap_b done");
  endtask

  task automatic test_video_on_b;
    restart_b();
    n_cmp++; if (vga_b.video_on !== 1'b1) begin n_bad++; $display("FAIL von_b_0_0 got %b want 1", vga_b.video_on); end
    step(4 * 52);
    n_cmp++; if (vga_b.x !== 10'd7 || vga_b.y !== 10'd3 || vga_b.video_on !== 1'b1) begin n_bad++; $display("FAIL von_b_7_3 got (%0d,%0d) von=%b want (7,3) 1", vga_b.x, vga_b.y, vga_b.video_on); end
    step(4);
    n_cmp++; if (vga_b.x !== 10'd8 || vga_b.video_on !== 1'b0) begin n_bad++; $display("FAIL von_b_8_3 got x=%0d von=%b want 8 0", vga_b.x, vga_b.video_on); end
    step(4 * 7);
    n_cmp++; if (vga_b.x !== 10'd0 || vga_b.y !== 10'd4 || vga_b.video_on !== 1'b0) begin n_bad++; $display("FAIL von_b_0_4 got (%0d,%0d) von=%b want (0,4) 0", vga_b.x, vga_b.y, vga_b.video_on); end
    $display("test_video_on_b done");
  endtask

  task automatic test_async_reset_b;
    restart_b();
    step(4 * 86);
    n_cmp++; if (vga_b.hsync !== 1'b0 || vga_b.vsync !== 1'b0) begin n_bad++; $display("FAIL areset_b_pre got hs=%b vs=%b want 0 0", vga_b.hsync, vga_b.vsync); end
    #2 rst_b = 1'b1;
    #1;
    n_cmp++; if (vga_b.hsync !== 1'b1 || vga_b.vsync !== 1'b1) begin n_bad++; $display("FAIL areset_b_sync got hs=%b vs=%b want 1 1", vga_b.hsync, vga_b.vsync); end
    n_cmp++; if (vga_b.x !== 10'd0 || vga_b.y !== 10'd0) begin n_bad++; $display("FAIL areset_b_xy got (%0d,%0d) want (0,0)", vga_b.x, vga_b.y); end
    @(negedge clk);
    rst_b = 1'b0;
    step(4);
    n_cmp++; if (vga_b.x !== 10'd1 || vga_b.frame_start !== 1'b0) begin n_bad++; $display("FAIL areset_b_restart got x=%0d fs=%b want 1 0", vga_b.x, vga_b.frame_start); end
    $display("test_async_reset_b done");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    test_reset();
    test_ptick_startup();
    test_line_boundary();
    test_video_on_a();
    test_async_reset_a();
    test_frame_b();
    test_wrap_b();
    test_video_on_b();
    test_async_reset_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
